// File: rtl/ftdi_tx_stream_arbiter.sv
// Packet-granular round-robin arbiter: shares one 32-bit AXI-stream TX port
// among N_SRC requesters, holding each grant until that packet's tlast beat.
module ftdi_tx_stream_arbiter #(
  parameter int N_SRC = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC-1:0]       i_tvalid,
  output logic [N_SRC-1:0]       i_tready,
  input  logic [32*N_SRC-1:0]    i_tdata,
  input  logic [4*N_SRC-1:0]     i_tkeep,
  input  logic [N_SRC-1:0]       i_tlast,
  output logic                   o_tvalid,
  input  logic                   o_tready,
  output logic [31:0]            o_tdata,
  output logic [3:0]             o_tkeep,
  output logic                   o_tlast,
  output logic [N_SRC-1:0]       grant,
  output logic                   busy,
  output logic [CNT_W*N_SRC-1:0] pkt_cnt
);

  localparam int PTR_W = $clog2(N_SRC);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [N_SRC-1:0]            grant_q, grant_d;
  logic [PTR_W-1:0]            ptr_q, ptr_d;
  logic [N_SRC-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_SRC-1:0]            win_s;
  logic [PTR_W-1:0]            nxt_ptr_s;
  logic                        found_s;
  logic                        hit_s;
  logic                        eop_s;

  // Round-robin winner: first pass covers sources at or above ptr, second wraps below it.
  always_comb begin
    win_s   = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      hit_s    = i_tvalid[k] && (PTR_W'(k) >= ptr_q) && !found_s;
      win_s[k] = hit_s;
      found_s  = found_s | hit_s;
    end
    for (int k = 0; k < N_SRC; k++) begin
      hit_s    = i_tvalid[k] && (PTR_W'(k) < ptr_q) && !found_s;
      win_s[k] = win_s[k] | hit_s;
      found_s  = found_s | hit_s;
    end
  end

  // One-hot AND-OR mux keyed only by the registered grant; idle forces zeros.
  always_comb begin
    o_tvalid  = 1'b0;
    o_tdata   = 32'h0000_0000;
    o_tkeep   = 4'h0;
    o_tlast   = 1'b0;
    i_tready  = '0;
    nxt_ptr_s = '0;
    for (int k = 0; k < N_SRC; k++) begin
      o_tvalid    = o_tvalid | (grant_q[k] & i_tvalid[k]);
      o_tdata     = o_tdata | ({32{grant_q[k]}} & i_tdata[32*k +: 32]);
      o_tkeep     = o_tkeep | ({4{grant_q[k]}} & i_tkeep[4*k +: 4]);
      o_tlast     = o_tlast | (grant_q[k] & i_tlast[k]);
      i_tready[k] = grant_q[k] & o_tready;
      nxt_ptr_s   = nxt_ptr_s | ({PTR_W{grant_q[k]}} & PTR_W'((k + 1) % N_SRC));
    end
  end

  assign eop_s = o_tvalid & o_tready & o_tlast;

  // Next-state: arbitrate from IDLE, release grant and bump counter on the last beat.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|i_tvalid) begin
          state_d = ST_BUSY;
          grant_d = win_s;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      ST_BUSY: begin
        if (eop_s) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = nxt_ptr_s;
          for (int k = 0; k < N_SRC; k++) begin
            cnt_d[k] = cnt_q[k] + CNT_W'(grant_q[k]);
          end
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset; a partial packet is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q == ST_BUSY);
  assign pkt_cnt = cnt_q;

endmodule

// File: tb/tb_ftdi_tx_stream_arbiter.sv
// Randomized scoreboard bench for ftdi_tx_stream_arbiter: a packet-level
// reference model predicts per-cycle ownership and the forwarded beat stream.
module tb_ftdi_tx_stream_arbiter;
  localparam int N  = 3;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    i_tvalid, i_tready, i_tlast, grant;
  logic [32*N-1:0] i_tdata;
  logic [4*N-1:0]  i_tkeep;
  logic            o_tvalid, o_tready, o_tlast, busy;
  logic [31:0]     o_tdata;
  logic [3:0]      o_tkeep;
  logic [CW*N-1:0] pkt_cnt;

  always #5 clk = ~clk;

  ftdi_tx_stream_arbiter #(.N_SRC(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_tvalid(i_tvalid), .i_tready(i_tready), .i_tdata(i_tdata),
    .i_tkeep(i_tkeep), .i_tlast(i_tlast),
    .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tdata(o_tdata),
    .o_tkeep(o_tkeep), .o_tlast(o_tlast),
    .grant(grant), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [N-1:0]    grant;
    logic            busy;
    logic            tvalid;
    logic [N-1:0]    tready;
    beat_t           out;
    logic [CW*N-1:0] cnt;
  } stat_t;

  beat_t src_q [N][$];
  beat_t mdl_q [N][$];
  beat_t exp_q [$];
  stat_t stat_q [$];

  int checks   = 0;
  int failures = 0;
  int vprob [N];
  int rprob;
  int acc [N];
  int rst_req_cnt = 0;
  int rst_target  = -1;
  logic started = 1'b0;

  int owner = -1;
  int ptr   = 0;
  int cnt [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_beat(input int k, input logic [31:0] d, input logic [3:0] kp, input logic l);
    beat_t b;
    b.data = d;
    b.keep = kp;
    b.last = l;
    src_q[k].push_back(b);
    mdl_q[k].push_back(b);
  endtask

  task automatic push_rand_pkt(input int k, input int len);
    for (int i = 0; i < len; i++)
      push_beat(k, $urandom, 4'($urandom_range(15)), (i == len - 1));
  endtask

  task automatic wait_drain(input int budget);
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(posedge clk); #3;
      n++;
      done = (exp_q.size() == 0) && (owner < 0);
      for (int k = 0; k < N; k++)
        if (src_q[k].size() != 0) done = 1'b0;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout: got pending expected drained within %0d cycles", budget);
    end
  endtask

  // Source drivers, o_tready and rst; only this process writes DUT inputs.
  initial begin : driver
    logic [N-1:0] hs;
    int cyc;
    int rst_done;
    int fired_target;
    beat_t b;
    cyc = 0; rst_done = 0; fired_target = -1;
    rst = 1'b1; o_tready = 1'b0;
    i_tvalid = '0; i_tdata = '0; i_tkeep = '0; i_tlast = '0;
    for (int k = 0; k < N; k++) acc[k] = 0;
    forever begin
      @(negedge clk);
      hs = i_tvalid & i_tready;
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) started = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (hs[k] && src_q[k].size() > 0) begin
          void'(src_q[k].pop_front());
          acc[k]++;
        end
        if (src_q[k].size() > 0) begin
          b = src_q[k][0];
          i_tvalid[k]         = ($urandom_range(99) < vprob[k]);
          i_tdata[32*k +: 32] = b.data;
          i_tkeep[4*k +: 4]   = b.keep;
          i_tlast[k]          = b.last;
        end else begin
          i_tvalid[k]         = 1'b0;
          i_tdata[32*k +: 32] = $urandom;
          i_tkeep[4*k +: 4]   = 4'($urandom_range(15));
          i_tlast[k]          = 1'($urandom_range(1));
        end
      end
      if (cyc < 3) begin
        rst = 1'b1; o_tready = 1'b0;
      end else if (rst_req_cnt > rst_done) begin
        rst_done++;
        rst = 1'b1; o_tready = 1'b0;
      end else if (rst_target >= 0 && acc[1] == rst_target && fired_target != rst_target) begin
        fired_target = rst_target;
        rst = 1'b1; o_tready = 1'b0;
      end else begin
        rst = 1'b0;
        o_tready = ($urandom_range(99) < rprob);
      end
    end
  end

  // Reference model: owner/ptr as integers, packets as queues; predicts each cycle.
  initial begin : model
    stat_t s;
    beat_t b;
    for (int k = 0; k < N; k++) cnt[k] = 0;
    wait (started);
    forever begin
      @(negedge clk);
      s = '0;
      for (int k = 0; k < N; k++) s.cnt[CW*k +: CW] = CW'(cnt[k]);
      if (owner >= 0) begin
        s.grant[owner]  = 1'b1;
        s.busy          = 1'b1;
        s.tvalid        = i_tvalid[owner];
        s.tready[owner] = o_tready;
        s.out.data      = i_tdata[32*owner +: 32];
        s.out.keep      = i_tkeep[4*owner +: 4];
        s.out.last      = i_tlast[owner];
      end
      stat_q.push_back(s);
      if (rst) begin
        owner = -1;
        ptr   = 0;
        for (int k = 0; k < N; k++) cnt[k] = 0;
      end else if (owner >= 0) begin
        if (i_tvalid[owner] && o_tready) begin
          if (mdl_q[owner].size() == 0) begin
            chk("model_underrun", 64'(mdl_q[owner].size()), 64'd1);
          end else begin
            b = mdl_q[owner].pop_front();
            exp_q.push_back(b);
            if (b.last) begin
              cnt[owner] = (cnt[owner] + 1) % (1 << CW);
              ptr   = (owner + 1) % N;
              owner = -1;
            end
          end
        end
      end else begin
        for (int j = 0; j < N; j++)
          if (owner < 0 && i_tvalid[(ptr + j) % N]) owner = (ptr + j) % N;
      end
    end
  end

  // Monitor: samples the DUT mid-cycle and pops predictions from the scoreboard.
  initial begin : monitor
    stat_t s;
    beat_t b, act_b;
    logic [N-1:0] g_c, rdy_c;
    logic busy_c, v_c, r_c;
    logic [CW*N-1:0] cnt_c;
    wait (started);
    forever begin
      @(negedge clk);
      g_c = grant; busy_c = busy; v_c = o_tvalid; r_c = o_tready; rdy_c = i_tready;
      act_b.data = o_tdata; act_b.keep = o_tkeep; act_b.last = o_tlast;
      cnt_c = pkt_cnt;
      #1;
      if (stat_q.size() == 0) begin
        chk("status_queue", 64'd0, 64'd1);
      end else begin
        s = stat_q.pop_front();
        chk("grant", 64'(g_c), 64'(s.grant));
        chk("busy", 64'(busy_c), 64'(s.busy));
        chk("o_tvalid", 64'(v_c), 64'(s.tvalid));
        chk("i_tready", 64'(rdy_c), 64'(s.tready));
        chk("o_beat_mux", 64'(act_b), 64'(s.out));
        chk("pkt_cnt", 64'(cnt_c), 64'(s.cnt));
      end
      if (v_c && r_c) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(act_b), 64'd0);
        end else begin
          b = exp_q.pop_front();
          chk("beat_stream", 64'(act_b), 64'(b));
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base, n;
    for (int k = 0; k < N; k++) vprob[k] = 100;
    rprob = 100;
    wait (started);
    repeat (4) @(posedge clk);
    #3;
    chk("reset_cnt", 64'(pkt_cnt), 64'd0);

    // Single 3-beat packet from src0.
    push_beat(0, 32'h1111_1111, 4'hF, 1'b0);
    push_beat(0, 32'h2222_2222, 4'hF, 1'b0);
    push_beat(0, 32'h3333_3333, 4'hF, 1'b1);
    wait_drain(100);
    chk("single_cnt0", 64'(pkt_cnt[CW-1:0]), 64'd1);

    // Fairness: both sources keep 2-beat packets pending.
    for (int p = 0; p < 4; p++) begin
      push_rand_pkt(0, 2);
      push_rand_pkt(1, 2);
    end
    wait_drain(200);
    chk("fair_cnt0", 64'(pkt_cnt[CW-1:0]), 64'd5);
    chk("fair_cnt1", 64'(pkt_cnt[2*CW-1:CW]), 64'd4);

    // Backpressure on a 4-beat src1 packet.
    rprob = 50;
    push_rand_pkt(1, 4);
    wait_drain(200);
    chk("bp_cnt1", 64'(pkt_cnt[2*CW-1:CW]), 64'd5);

    // Source stall while another source waits.
    rprob = 100; vprob[0] = 40;
    push_rand_pkt(0, 3);
    push_rand_pkt(1, 2);
    wait_drain(300);

    // Random traffic on all sources with stalls and backpressure.
    for (int k = 0; k < N; k++) vprob[k] = 60;
    rprob = 70;
    for (int p = 0; p < 40; p++) push_rand_pkt($urandom_range(N - 1), $urandom_range(1, 5));
    wait_drain(3000);

    // Reset mid-packet: ptr left at 1 by src0, then src1 is cut after beat 2.
    for (int k = 0; k < N; k++) vprob[k] = 100;
    rprob = 100;
    push_rand_pkt(0, 1);
    wait_drain(100);
    base = acc[1];
    rst_target = base + 2;
    push_rand_pkt(1, 4);
    n = 0;
    while (acc[1] < base + 2 && n < 100) begin
      @(posedge clk); #3;
      n++;
    end
    chk("rst_trigger", 64'(acc[1]), 64'(base + 2));
    push_rand_pkt(0, 1);
    @(posedge clk); #3;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt", 64'(pkt_cnt), 64'd0);
    @(posedge clk); #3;
    chk("rst_src0_wins", 64'(grant), 64'd1);
    wait_drain(200);
    chk("rst_after_cnt0", 64'(pkt_cnt[CW-1:0]), 64'd1);
    chk("rst_after_cnt1", 64'(pkt_cnt[2*CW-1:CW]), 64'd1);

    // Counter wrap: 17 single-beat packets after a clean reset.
    rst_req_cnt++;
    repeat (3) @(posedge clk);
    #3;
    for (int p = 0; p < 17; p++) push_rand_pkt(0, 1);
    wait_drain(300);
    chk("wrap_cnt0", 64'(pkt_cnt[CW-1:0]), 64'd1);

    repeat (3) @(posedge clk);
    chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ftdi_tx_stream_arbiter.md
# ftdi_tx_stream_arbiter

Packet-granular round-robin arbiter that shares the single 32-bit TX AXI-stream input of `ftdi_245fifo_top` among N independent requesters, such as the command processor's responses and bulk ADC data. Each requester presents complete packets delimited by `tlast`. Once a requester is granted, the arbiter holds the grant until that packet's `tlast` beat is accepted, so packets never interleave on the USB link. It sits in the `clk` domain, between the requesters and `tx_tready/tx_tvalid/tx_tdata/tx_tkeep/tx_tlast` of `ftdi_245fifo_top`.

## Interface
- `N_SRC`, default 2: number of requesters; legal range 2..8.
- `CNT_W`, default 16: width of each per-source packet counter.

Ports:
- `clk` input 1: system clock (the `clk` that drives `tx_clk` of `ftdi_245fifo_top`).
- `rst` input 1: synchronous reset, active-high.
- `i_tvalid` input N_SRC: per-source valid; bit k belongs to source k.
- `i_tready` output N_SRC: per-source ready.
- `i_tdata` input 32*N_SRC: source k occupies bits [32k+31:32k].
- `i_tkeep` input 4*N_SRC: source k occupies bits [4k+3:4k].
- `i_tlast` input N_SRC: per-source end-of-packet.
- `o_tvalid` output 1: to `tx_tvalid`.
- `o_tready` input 1: from `tx_tready`.
- `o_tdata` output 32: to `tx_tdata`.
- `o_tkeep` output 4: to `tx_tkeep`.
- `o_tlast` output 1: to `tx_tlast`.
- `grant` output N_SRC: one-hot current owner; all zeros when idle.
- `busy` output 1: high while a packet is being forwarded.
- `pkt_cnt` output CNT_W*N_SRC: packets completed per source; source k occupies bits [CNT_W*k+CNT_W-1:CNT_W*k].

## Operation
- There are two states, IDLE and BUSY.
- The arbiter keeps a round-robin pointer `ptr` of width clog2(N_SRC).
- **IDLE**
  - `grant`=0, `o_tvalid`=0, all `i_tready`=0.
  - If any `i_tvalid` is high, the winner is the first asserted source searching from `ptr` upward, wrapping at N_SRC-1 back to 0.
  - The winner is registered into `grant` and the state goes to BUSY.
- **BUSY**
  - The output is a combinational pass-through of the granted source: `o_tvalid/o_tdata/o_tkeep/o_tlast` = source signals, and `i_tready[g]` = `o_tready`.
  - Every other `i_tready` is 0.
- **End of packet**
  - Triggered by a beat with `o_tvalid & o_tready & o_tlast`.
  - Next state is IDLE, `ptr` = g+1 (mod N_SRC), and `pkt_cnt[g]` increments.
  - Counters wrap from 2^CNT_W-1 to 0.
- The arbiter never re-grants in the same cycle a packet ends. A source that keeps valid asserted therefore loses to a waiting lower-priority source on the next arbitration.
- A granted source that deasserts `i_tvalid` mid-packet keeps the grant; the output simply shows `o_tvalid`=0. There is no timeout.
- `tkeep` is forwarded unmodified, including 0000 beats and partial `tkeep` on non-last beats.
- Source changes to `tvalid` on non-granted ports are ignored until arbitration.
- **Reset** (including mid-packet)
  - On the next edge: state IDLE, `grant`=0, `ptr`=0, all `pkt_cnt`=0, `busy`=0.
  - The partial packet is abandoned; its remainder is treated as a new packet at the next grant.

## Timing
- Reset values: `o_tvalid`=0, `o_tlast`=0, `o_tdata`=0, `o_tkeep`=0, `i_tready`=0, `grant`=0, `busy`=0, `pkt_cnt`=0.
- Outputs are forced to zero whenever `grant`=0, so `o_tdata/o_tkeep/o_tlast` are 0 while idle.
- Arbitration latency: `i_tvalid` rising in IDLE at edge t gives `grant`/`busy` high after edge t+1, and the first beat can transfer in the cycle following t+1.
- Throughput: one beat per cycle while BUSY with `o_tready`=1.
- Per-packet overhead is exactly one idle cycle (the IDLE arbitration cycle).
- The combinational path `o_tready` -> `i_tready[g]` is allowed.
- The path `i_*` -> `o_*` is combinational through a mux selected by the registered `grant` only; there is no path from `i_tvalid` to `grant` in the same cycle.
- `pkt_cnt` and `ptr` update on the edge that accepts the last beat.

## Test plan
- **Single source:** src0 sends a 3-beat packet (tdata 0x11111111, 0x22222222, 0x33333333; tlast on beat 3) with `o_tready`=1 -> `grant`=01 one cycle after valid, 3 consecutive output beats, then IDLE for one cycle, `pkt_cnt[0]`=1.
- **Fairness:** src0 and src1 both hold valid with continuous 2-beat packets for 8 packets -> grants alternate 0,1,0,1…, each source's `pkt_cnt` = 4, and no beat of one packet appears inside another.
- **Backpressure:** `o_tready` toggles 1,0,0,1 during a 4-beat src1 packet -> `i_tready[1]` mirrors `o_tready`, `i_tready[0]`=0 throughout, and the data order is preserved.
- **Source stall:** src0 drops `tvalid` for 3 cycles after beat 1 while src1 is valid -> the grant stays on src0, `o_tvalid`=0 for 3 cycles, and src1 is granted only after src0's `tlast`.
- **Reset mid-packet:** assert `rst` for 1 cycle after beat 2 of a 4-beat src1 packet -> next cycle `grant`=0, `busy`=0, `pkt_cnt`=0, `ptr`=0; with both valid afterwards, src0 wins.
- **Counter wrap:** with CNT_W=4, send 17 one-beat src0 packets -> `pkt_cnt[0]` reads 1.
